riscv_run_ctrl: RTL and testbench

Run controller that sequences the single-cycle RISC-V core for a test or host session. It streams a program from a host valid/ready interface into instruction memory, holds the core in reset during loading, then releases it from a latched start PC. It counts execution cycles until the core raises `fin`, a timeout expires or the host aborts, and it reports a status code with the cycle count. It sits between the host/testbench and the `riscv` top: it drives the core's reset and `init_pc`, and the write port of instruction memory.

---
 rtl/riscv_run_ctrl.sv | 101 ++++++++++
 tb/tb_riscv_run_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/riscv_run_ctrl.sv
// riscv_run_ctrl: loads a program into imem, releases the core from a latched PC,
// and reports how the run ended together with its cycle count.
module riscv_run_ctrl #(
    parameter int WIDTH = 32,
    parameter int IADDR = 16,
    parameter int CYC_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             host_start,
    input  logic [WIDTH-1:0] start_pc,
    input  logic [CYC_W-1:0] timeout,
    input  logic             host_valid,
    output logic             host_ready,
    input  logic [WIDTH-1:0] host_data,
    input  logic             host_last,
    input  logic             abort,
    output logic             imem_wr_en,
    output logic [IADDR-1:0] imem_wr_addr,
    output logic [WIDTH-1:0] imem_wr_data,
    output logic             core_reset_n,
    output logic [WIDTH-1:0] core_init_pc,
    input  logic             core_fin,
    output logic             busy,
    output logic             done,
    output logic [1:0]       status,
    output logic [CYC_W-1:0] cycle_count
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t           state, state_n;
    logic [1:0]       status_n;
    logic [IADDR-1:0] addr;
    logic [CYC_W-1:0] tmo, cnt_inc;
    logic             xfer, launch;

    assign host_ready   = state == LOAD;
    assign xfer         = host_valid && host_ready;
    assign imem_wr_en   = xfer;
    assign imem_wr_addr = addr;
    assign imem_wr_data = host_data;
    assign busy         = state == LOAD || state == RUN;
    assign done         = state == DONE;
    assign launch       = (state == IDLE || state == DONE) && host_start;
    assign cnt_inc      = &cycle_count ? cycle_count : cycle_count + CYC_W'(1);

    always_comb begin
        state_n  = state;
        status_n = status;
        case (state)
            IDLE, DONE: if (host_start) begin
                state_n  = LOAD;
                status_n = 2'b00;
            end
            LOAD: if (abort || (xfer && !host_last && &addr)) begin
                state_n  = DONE;
                status_n = 2'b11;
            end else if (xfer && host_last) begin
                state_n  = RUN;
            end
            RUN: if (abort) begin
                state_n  = DONE;
                status_n = 2'b11;
            end else if (core_fin) begin
                state_n  = DONE;
                status_n = 2'b01;
            end else if (tmo != '0 && cnt_inc == tmo) begin
                state_n  = DONE;
                status_n = 2'b10;
            end
            default: state_n = IDLE;
        endcase
    end

    // core reset follows the next state so the core runs exactly during RUN cycles
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            status       <= 2'b00;
            core_reset_n <= 1'b0;
            core_init_pc <= '0;
            tmo          <= '0;
            addr         <= '0;
            cycle_count  <= '0;
        end else begin
            state        <= state_n;
            status       <= status_n;
            core_reset_n <= state_n == RUN;
            if (launch) begin
                core_init_pc <= start_pc;
                tmo          <= timeout;
                addr         <= '0;
                cycle_count  <= '0;
            end
            if (xfer && !(&addr))
                addr <= addr + IADDR'(1);
            if (state == RUN)
                cycle_count <= cnt_inc;
        end
    end
endmodule

// File: tb/tb_riscv_run_ctrl.sv
// tb_riscv_run_ctrl: directed sequence of sessions with immediate-assertion checks;
// a second instance with a 4-word instruction memory covers load overflow.
module tb_riscv_run_ctrl;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        host_start = 1'b0, s_start = 1'b0;
    logic [31:0] start_pc = '0, timeout = '0, host_data = '0;
    logic        host_valid = 1'b0, host_last = 1'b0, abort = 1'b0, core_fin = 1'b0;

    logic        host_ready, imem_wr_en, core_reset_n, busy, done;
    logic [15:0] imem_wr_addr;
    logic [31:0] imem_wr_data, core_init_pc, cycle_count;
    logic [1:0]  status;

    logic        s_ready, s_wr_en, s_core_reset_n, s_busy, s_done;
    logic [1:0]  s_wr_addr, s_status;
    logic [31:0] s_wr_data, s_init_pc, s_cycle;

    int ncmp = 0, nerr = 0, hi;

    always #5 clk = ~clk;

    riscv_run_ctrl dut (
        .clk(clk), .reset_n(reset_n), .host_start(host_start), .start_pc(start_pc),
        .timeout(timeout), .host_valid(host_valid), .host_ready(host_ready),
        .host_data(host_data), .host_last(host_last), .abort(abort),
        .imem_wr_en(imem_wr_en), .imem_wr_addr(imem_wr_addr), .imem_wr_data(imem_wr_data),
        .core_reset_n(core_reset_n), .core_init_pc(core_init_pc), .core_fin(core_fin),
        .busy(busy), .done(done), .status(status), .cycle_count(cycle_count)
    );

    riscv_run_ctrl #(.WIDTH(32), .IADDR(2), .CYC_W(32)) u_small (
        .clk(clk), .reset_n(reset_n), .host_start(s_start), .start_pc(start_pc),
        .timeout(timeout), .host_valid(host_valid), .host_ready(s_ready),
        .host_data(host_data), .host_last(host_last), .abort(abort),
        .imem_wr_en(s_wr_en), .imem_wr_addr(s_wr_addr), .imem_wr_data(s_wr_data),
        .core_reset_n(s_core_reset_n), .core_init_pc(s_init_pc), .core_fin(core_fin),
        .busy(s_busy), .done(s_done), .status(s_status), .cycle_count(s_cycle)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // counts cycles with core_reset_n high; bounded so a stuck RUN still terminates
    task automatic run_phase(input int fin_at, input int ab_at);
        hi = 0;
        for (int k = 1; k <= 40 && core_reset_n === 1'b1; k++) begin
            core_fin = k == fin_at;
            abort    = k == ab_at;
            hi++;
            tick();
        end
        core_fin = 1'b0;
        abort    = 1'b0;
    endtask

    task automatic session(input logic [31:0] pc, input logic [31:0] tmo, input int fin_at, input int ab_at);
        start_pc = pc; timeout = tmo; host_start = 1'b1;
        tick();
        host_start = 1'b0; host_valid = 1'b1; host_last = 1'b1; host_data = 32'h13;
        tick();
        host_valid = 1'b0; host_last = 1'b0;
        run_phase(fin_at, ab_at);
    endtask

    initial begin
        #3;
        chk("rst_core_reset_n", core_reset_n, 0);
        chk("rst_busy_done", {busy, done}, 0);
        chk("rst_status", status, 0);
        chk("rst_ready_wr", {host_ready, imem_wr_en}, 0);
        chk("rst_addr", imem_wr_addr, 0);
        chk("rst_cycle", cycle_count, 0);
        #20 reset_n = 1'b1;

        // four-word load, fin in the 10th RUN cycle
        start_pc = 32'h0; timeout = 32'h0; host_start = 1'b1;
        tick();
        host_start = 1'b0;
        chk("t1_ready", host_ready, 1);
        chk("t1_load_busy", {busy, done}, 2'b10);
        chk("t1_load_core_reset", core_reset_n, 0);
        for (int i = 0; i < 4; i++) begin
            host_valid = 1'b1; host_last = i == 3;
            host_data = i == 3 ? 32'h6F : 32'h13;
            #1;
            chk("t1_wr_en", imem_wr_en, 1);
            chk("t1_wr_addr", imem_wr_addr, i);
            chk("t1_wr_data", imem_wr_data, i == 3 ? 32'h6F : 32'h13);
            tick();
        end
        host_valid = 1'b0; host_last = 1'b0;
        chk("t1_run_core_reset", core_reset_n, 1);
        chk("t1_run_cycle0", cycle_count, 0);
        chk("t1_run_wr_en", {host_ready, imem_wr_en}, 0);
        run_phase(10, 0);
        chk("t1_hi_cycles", hi, 10);
        chk("t1_done", {busy, done}, 2'b01);
        chk("t1_status", status, 2'b01);
        chk("t1_cycle", cycle_count, 10);
        chk("t1_done_core_reset", core_reset_n, 0);

        // timeout of 5 without fin
        session(32'h100, 32'd5, 0, 0);
        chk("t2_hi_cycles", hi, 5);
        chk("t2_status", status, 2'b10);
        chk("t2_cycle", cycle_count, 5);
        chk("t2_init_pc", core_init_pc, 32'h100);

        // fin coincident with timeout, then also with abort
        session(32'h200, 32'd3, 3, 0);
        chk("t3_hi_cycles", hi, 3);
        chk("t3_status", status, 2'b01);
        chk("t3_cycle", cycle_count, 3);
        session(32'h200, 32'd3, 3, 3);
        chk("t3b_status", status, 2'b11);
        chk("t3b_done", done, 1);

        // overflow on the 4-word instance (main instance stays in DONE)
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            host_valid = 1'b1; host_last = 1'b0; host_data = 32'hA0 + i;
            #1;
            chk("t4_ready", s_ready, i < 4);
            chk("t4_wr_en", s_wr_en, i < 4);
            if (i < 4) chk("t4_wr_addr", s_wr_addr, i);
            tick();
        end
        host_valid = 1'b0;
        chk("t4_status", s_status, 2'b11);
        chk("t4_done", s_done, 1);
        chk("t4_main_untouched", {done, status}, 3'b1_11);

        // abort in LOAD with a coincident transfer
        start_pc = 32'h0; timeout = 32'h0; host_start = 1'b1;
        tick();
        host_start = 1'b0; host_valid = 1'b1; host_data = 32'h55; abort = 1'b1;
        #1;
        chk("t5_abort_wr_en", imem_wr_en, 1);
        tick();
        host_valid = 1'b0; abort = 1'b0;
        chk("t5_abort_status", status, 2'b11);
        chk("t5_abort_done", {busy, done, core_reset_n}, 3'b010);

        // gapped load with host_start pulses ignored, then reset mid-RUN
        start_pc = 32'h40; timeout = 32'h0; host_start = 1'b1;
        tick();
        start_pc = 32'hDEAD;
        for (int i = 0; i < 4; i++) begin
            host_valid = i != 1; host_last = i == 3; host_data = 32'hB0 + i;
            #1;
            chk("t6_wr_en", imem_wr_en, i != 1);
            if (i != 1) chk("t6_wr_addr", imem_wr_addr, i == 0 ? 0 : i - 1);
            tick();
        end
        host_valid = 1'b0; host_last = 1'b0; host_start = 1'b0;
        chk("t6_run", core_reset_n, 1);
        chk("t6_init_pc", core_init_pc, 32'h40);
        repeat (7) tick();
        chk("t6_cycle7", cycle_count, 7);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_async_core_reset", core_reset_n, 0);
        chk("t6_rst_flags", {busy, done, host_ready, status}, 0);
        chk("t6_rst_cycle", cycle_count, 0);
        chk("t6_rst_pc_addr", {core_init_pc, 16'h0, imem_wr_addr}, 0);
        reset_n = 1'b1;
        session(32'h300, 32'd2, 0, 0);
        chk("t6_new_status", status, 2'b10);
        chk("t6_new_cycle", cycle_count, 2);
        chk("t6_new_pc", core_init_pc, 32'h300);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
